// File: rtl/dl_pkg.sv
// Shared definitions for the delay line: the reset value of stored data and the
// helper that maps a requested delay onto a legal tap index.
package dl_pkg;

    // Value every stored data/valid bit takes on reset or flush.
    localparam logic RST_BIT = 1'b0;

    // Clamp a requested delay into 1..depth; 0 behaves as 1, oversize as depth.
    function automatic int unsigned clamp_tap(input int unsigned sel, input int unsigned depth);
        int unsigned res;
        res = sel;
        if (sel == 0) begin
            res = 1;
        end else if (sel > depth) begin
            res = depth;
        end
        return res;
    endfunction

endpackage

// File: rtl/delay_line_stage.sv
// One register of the delay chain: holds {data, vld} as a single W-bit word.
// Ports: clk, rst (async, active-low), en (load d), clr (sync clear, wins over en),
//        d (next word), q (stored word).
module delay_line_stage
    import dl_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {W{RST_BIT}};
        end else if (clr) begin
            q <= {W{RST_BIT}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/delay_line.sv
// Stallable, flushable delay line with a runtime-selectable tap and per-stage valid.
// Ports: clk, rst (async, active-low), en (advance), flush (sync clear, beats en),
//        d/d_vld (input sample), dly_sel (requested delay, clamped to 1..DEPTH),
//        q/q_vld (sample at the selected tap, combinational from the stages),
//        primed (at least eff en-cycles of history since reset/flush).
module delay_line
    import dl_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned SELW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    input  logic [SELW-1:0]  dly_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic             primed
);

    localparam int unsigned SW = WIDTH + 1;

    logic [SW-1:0]   stg_d [DEPTH];
    logic [SW-1:0]   stg_q [DEPTH];
    logic [SELW-1:0] fill;
    logic [SELW-1:0] eff;

    // Stage chain: stage 0 takes the input word, every later stage its predecessor.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stg_d[i] = {d, d_vld};
        end else begin : g_body
            assign stg_d[i] = stg_q[i-1];
        end

        delay_line_stage #(
            .W (SW)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .clr (flush),
            .d   (stg_d[i]),
            .q   (stg_q[i])
        );
    end

    // History counter: saturates at DEPTH so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill <= '0;
        end else if (flush) begin
            fill <= '0;
        end else if (en && (fill != SELW'(DEPTH))) begin
            fill <= fill + SELW'(1);
        end
    end

    assign eff = SELW'(clamp_tap(32'(dly_sel), DEPTH));

    // Tap mux: stage eff-1 drives the output; a sel change takes effect immediately.
    always_comb begin
        q     = '0;
        q_vld = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (eff == SELW'(i + 1)) begin
                q     = stg_q[i][SW-1:1];
                q_vld = stg_q[i][0];
            end
        end
    end

    assign primed = (fill >= eff);

endmodule

// File: tb/tb_delay_line.sv
module tb_delay_line;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SELW  = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_vld;
    logic [SELW-1:0]  dly_sel;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic             primed;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             vld;
        logic             primed;
    } exp_t;

    exp_t sb[$];
    int   sb_id[$];
    exp_t mid_sb[$];
    int   mid_id[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    bit   done   = 1'b0;

    delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_vld   (d_vld),
        .dly_sel (dly_sel),
        .q       (q),
        .q_vld   (q_vld),
        .primed  (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; the expectation is what the outputs must show during
    // this cycle (state from the edge just passed, tap chosen by s).
    task automatic cyc(input logic e, input logic f, input logic [WIDTH-1:0] dd,
                       input logic v, input logic [SELW-1:0] s,
                       input logic [WIDTH-1:0] eq, input logic ev, input logic ep);
        exp_t x;
        @(posedge clk);
        #1;
        en      = e;
        flush   = f;
        d       = dd;
        d_vld   = v;
        dly_sel = s;
        cyc_no++;
        x.q = eq; x.vld = ev; x.primed = ep;
        sb.push_back(x);
        sb_id.push_back(cyc_no);
    endtask

    // Mid-cycle tap change: outputs must follow dly_sel without a clock edge.
    task automatic mid_chk(input logic [SELW-1:0] s, input logic [WIDTH-1:0] eq,
                           input logic ev, input logic ep);
        exp_t x;
        @(negedge clk);
        #1;
        dly_sel = s;
        x.q = eq; x.vld = ev; x.primed = ep;
        mid_sb.push_back(x);
        mid_id.push_back(cyc_no);
    endtask

    // Stimulus
    initial begin
        logic [WIDTH-1:0] fill_tab [8];
        rst = 1'b0; en = 1'b1; flush = 1'b0; d = 8'hFF; d_vld = 1'b1; dly_sel = 4'd2;
        fill_tab = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44};

        // Reset held with live inputs, then release and fill (sel=2).
        cyc(1, 0, 8'hFF, 1, 2, 8'h00, 0, 0);
        cyc(1, 0, 8'hFF, 1, 2, 8'h00, 0, 0);
        cyc(1, 0, 8'h0A, 1, 2, 8'h00, 0, 0);
        rst = 1'b1;
        cyc(1, 0, 8'h0B, 1, 2, 8'h00, 0, 0);
        cyc(1, 0, 8'h0C, 1, 2, 8'h0A, 1, 1);
        cyc(1, 0, 8'h0D, 1, 2, 8'h0B, 1, 1);
        cyc(1, 1, 8'h55, 1, 2, 8'h0C, 1, 1);

        // Stall with sel=3.
        cyc(1, 0, 8'h01, 1, 3, 8'h00, 0, 0);
        cyc(1, 0, 8'h02, 1, 3, 8'h00, 0, 0);
        cyc(1, 0, 8'h03, 1, 3, 8'h00, 0, 0);
        cyc(1, 0, 8'h04, 1, 3, 8'h01, 1, 1);
        cyc(0, 0, 8'h05, 1, 3, 8'h02, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'hEE, 0, 3, 8'h02, 1, 1);
        cyc(1, 0, 8'h05, 1, 3, 8'h02, 1, 1);
        cyc(1, 0, 8'h06, 1, 3, 8'h03, 1, 1);
        cyc(1, 0, 8'h07, 1, 3, 8'h04, 1, 1);
        cyc(1, 0, 8'h08, 1, 3, 8'h05, 1, 1);

        // Fill with 0x11..0x88 at sel=4, then flush together with en.
        for (int k = 0; k < 8; k++)
            cyc(1, 0, 8'((k + 1) * 8'h11), 1, 4, fill_tab[k], 1, 1);
        cyc(1, 1, 8'h99, 1, 4, 8'h55, 1, 1);
        cyc(1, 0, 8'hA1, 1, 4, 8'h00, 0, 0);
        cyc(1, 0, 8'hA2, 1, 4, 8'h00, 0, 0);
        cyc(1, 0, 8'hA3, 1, 4, 8'h00, 0, 0);
        cyc(1, 0, 8'hA4, 1, 4, 8'h00, 0, 0);
        cyc(1, 0, 8'hA5, 1, 4, 8'hA1, 1, 1);

        // Counter stream with tap changes 2 -> 5 -> 1 -> 0(clamped to 1).
        cyc(1, 0, 8'd0, 1, 2, 8'hA4, 1, 1);
        cyc(1, 0, 8'd1, 1, 2, 8'hA5, 1, 1);
        for (int n = 2; n < 20; n++) cyc(1, 0, 8'(n), 1, 2, 8'(n - 2), 1, 1);
        cyc(1, 0, 8'd20, 1, 2, 8'd18, 1, 1);
        mid_chk(5, 8'd15, 1, 1);
        cyc(1, 0, 8'd21, 1, 5, 8'd16, 1, 1);
        cyc(1, 0, 8'd22, 1, 5, 8'd17, 1, 1);
        cyc(1, 0, 8'd23, 1, 5, 8'd18, 1, 1);
        cyc(1, 0, 8'd24, 1, 1, 8'd23, 1, 1);
        cyc(1, 0, 8'd25, 1, 1, 8'd24, 1, 1);
        cyc(1, 0, 8'd26, 1, 0, 8'd25, 1, 1);
        cyc(1, 1, 8'd27, 1, 0, 8'd26, 1, 1);

        // Oversize select (15 behaves as 8); primed only after 8 en-edges.
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 8'(8'h30 + k), 1, 15, 8'h00, 0, 0);
            if (k == 3) mid_chk(0, 8'h32, 1, 1);
            if (k == 7) mid_chk(7, 8'h30, 1, 1);
        end
        cyc(1, 1, 8'h38, 1, 15, 8'h30, 1, 1);

        // Valid holes at sel=3.
        cyc(1, 0, 8'd5, 1, 3, 8'h00, 0, 0);
        cyc(1, 0, 8'd6, 0, 3, 8'h00, 0, 0);
        cyc(1, 0, 8'd7, 1, 3, 8'h00, 0, 0);
        cyc(1, 0, 8'd8, 1, 3, 8'd5, 1, 1);
        cyc(1, 0, 8'd0, 0, 3, 8'd6, 0, 1);
        cyc(1, 0, 8'd0, 0, 3, 8'd7, 1, 1);
        cyc(0, 0, 8'd0, 0, 3, 8'd8, 1, 1);

        // Asynchronous reset mid-stream, then restart from empty.
        cyc(1, 0, 8'h09, 1, 3, 8'h00, 0, 0);
        rst = 1'b0;
        cyc(1, 0, 8'h0A, 1, 3, 8'h00, 0, 0);
        rst = 1'b1;
        cyc(1, 0, 8'h0B, 1, 3, 8'h00, 0, 0);
        cyc(1, 0, 8'h0C, 1, 3, 8'h00, 0, 0);
        cyc(1, 0, 8'h0D, 1, 3, 8'h0A, 1, 1);
        cyc(1, 0, 8'h0E, 1, 3, 8'h0B, 1, 1);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

    // Monitor: compares presented outputs against queued expectations.
    initial begin
        exp_t e;
        int   id;
        while (!done) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                id = sb_id.pop_front();
                checks++;
                if (q !== e.q || q_vld !== e.vld || primed !== e.primed) begin
                    errors++;
                    $display("FAIL cycle%0d outputs: got q=%h q_vld=%b primed=%b, expected q=%h q_vld=%b primed=%b",
                             id, q, q_vld, primed, e.q, e.vld, e.primed);
                end
            end
            #2;
            if (mid_sb.size() != 0) begin
                e  = mid_sb.pop_front();
                id = mid_id.pop_front();
                checks++;
                if (q !== e.q || q_vld !== e.vld || primed !== e.primed) begin
                    errors++;
                    $display("FAIL cycle%0d tap_change: got q=%h q_vld=%b primed=%b, expected q=%h q_vld=%b primed=%b",
                             id, q, q_vld, primed, e.q, e.vld, e.primed);
                end
            end
        end
        checks++;
        if (sb.size() != 0 || mid_sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size() + mid_sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion before 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
